// File: rtl/pong_pkg.sv
// Shared definitions for the pong game-flow controller and its helpers.
//   - state_t      : controller state encodings (also reported on state_o)
//   - BCD_*        : widths/limits of the two-digit BCD score
//   - DEFAULT_WIN_SCORE : default points-to-win, also used by the text
//                    overlay for its "WIN" display
//   - to_bcd()     : constant conversion of a 0..99 integer to two BCD digits
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4,
    ST_PAUSE = 3'd5
  } state_t;

  localparam int BCD_DIGIT_W = 4;
  localparam int BCD_W       = 2 * BCD_DIGIT_W;
  localparam logic [BCD_W-1:0] BCD_MAX = 8'h99;

  localparam int DEFAULT_WIN_SCORE = 9;

  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned v);
    logic [BCD_DIGIT_W-1:0] tens;
    logic [BCD_DIGIT_W-1:0] units;
    tens  = BCD_DIGIT_W'((v / 10) % 10);
    units = BCD_DIGIT_W'(v % 10);
    return {tens, units};
  endfunction

endpackage

// File: rtl/pong_game_ctrl_bcd_counter2.sv
// Two-digit BCD up-counter used for one player's score.
// Ports:
//   clk      : system clock
//   reset_i  : synchronous active-high reset, count -> 00
//   clr_i    : synchronous clear, count -> 00 (wins over inc_i)
//   inc_i    : add one; units 9 wraps to 0 and carries into tens; 99 holds
//   count_o  : {tens, units} BCD value
module bcd_counter2
  import pong_pkg::*;
(
  input  logic             clk,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [BCD_W-1:0] count_o
);

  logic [BCD_DIGIT_W-1:0] tens_q, tens_d;
  logic [BCD_DIGIT_W-1:0] units_q, units_d;

  always_comb begin
    tens_d  = tens_q;
    units_d = units_q;
    if (clr_i) begin
      tens_d  = '0;
      units_d = '0;
    end else if (inc_i && ({tens_q, units_q} != BCD_MAX)) begin
      if (units_q == 4'd9) begin
        units_d = '0;
        tens_d  = tens_q + 4'd1;
      end else begin
        units_d = units_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  assign count_o = {tens_q, units_q};

endmodule

// File: rtl/pong_game_ctrl.sv
// Game-flow controller for two-player pong: IDLE -> SERVE -> PLAY -> POINT
// -> (SERVE | OVER) -> IDLE, with BCD scoring, a frame-timed serve delay and
// a frame-timed game-over hold.
// Optional build macro PONG_PAUSE_EN adds a PAUSE state (encoding 5) entered
// and left from PLAY by the btn1[1] & btn2[1] chord.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   frame_tick            : one-cycle pulse per video frame (paces timers)
//   btn1, btn2            : debounced player buttons
//   miss_left, miss_right : one-cycle miss pulses from the graphics unit
//   graph_still           : freeze ball motion (low only while playing)
//   ball_reset            : one-cycle recentre pulse, first cycle of SERVE
//   serve_dir             : 0 = serve toward left, 1 = toward right
//   left_score, right_score : BCD scores
//   game_over, winner     : game-over flag and winning side (0 left, 1 right)
//   state_o               : current state encoding
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int SERVE_FRAMES = 60,
  parameter int OVER_FRAMES  = 180,
  parameter int TW           = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [1:0] btn1,
  input  logic [1:0] btn2,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       graph_still,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [7:0] left_score,
  output logic [7:0] right_score,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_o
);

  localparam logic [BCD_W-1:0] WIN_BCD    = to_bcd(WIN_SCORE);
  localparam logic [TW-1:0]    SERVE_LAST = TW'(SERVE_FRAMES - 1);
  localparam logic [TW-1:0]    OVER_LAST  = TW'(OVER_FRAMES - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            serve_dir_q, serve_dir_d;
  logic            winner_q, winner_d;
  logic            ball_reset_q, ball_reset_d;
  logic            clr_scores, inc_left, inc_right;
  logic [BCD_W-1:0] left_bcd, right_bcd;
  logic            any_btn;

  assign any_btn = (|btn1) | (|btn2);

`ifdef PONG_PAUSE_EN
  // armed_q is set once every button is released inside PAUSE, so the chord
  // that entered PAUSE cannot immediately leave it again.
  logic chord;
  logic armed_q, armed_d;
  assign chord = btn1[1] & btn2[1];
`endif

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    ball_reset_d = 1'b0;
    clr_scores   = 1'b0;
    inc_left     = 1'b0;
    inc_right    = 1'b0;
`ifdef PONG_PAUSE_EN
    armed_d      = armed_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (any_btn) begin
          state_d      = ST_SERVE;
          ball_reset_d = 1'b1;
          clr_scores   = 1'b1;
          timer_d      = '0;
          serve_dir_d  = 1'b0;
          winner_d     = 1'b0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (timer_q == SERVE_LAST) begin
            state_d = ST_PLAY;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      ST_PLAY: begin
        // A miss takes priority over anything else seen in the same cycle.
        if (miss_left || miss_right) begin
          state_d = ST_POINT;
          if (miss_left && miss_right) begin
            serve_dir_d = ~serve_dir_q;
          end else if (miss_right) begin
            inc_left    = 1'b1;
            serve_dir_d = 1'b1;
          end else begin
            inc_right   = 1'b1;
            serve_dir_d = 1'b0;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (chord) begin
          state_d = ST_PAUSE;
          armed_d = 1'b0;
        end
`endif
      end
      ST_POINT: begin
        // Scores were updated on entry, so they already reflect this point.
        timer_d = '0;
        if (left_bcd == WIN_BCD) begin
          state_d  = ST_OVER;
          winner_d = 1'b0;
        end else if (right_bcd == WIN_BCD) begin
          state_d  = ST_OVER;
          winner_d = 1'b1;
        end else begin
          state_d      = ST_SERVE;
          ball_reset_d = 1'b1;
        end
      end
      ST_OVER: begin
        if (frame_tick) begin
          if (timer_q == OVER_LAST) begin
            state_d = ST_IDLE;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSE: begin
        if (!any_btn) begin
          armed_d = 1'b1;
        end else if (armed_q && chord) begin
          state_d = ST_PLAY;
        end
      end
`endif
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      serve_dir_q  <= 1'b0;
      winner_q     <= 1'b0;
      ball_reset_q <= 1'b0;
`ifdef PONG_PAUSE_EN
      armed_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      serve_dir_q  <= serve_dir_d;
      winner_q     <= winner_d;
      ball_reset_q <= ball_reset_d;
`ifdef PONG_PAUSE_EN
      armed_q      <= armed_d;
`endif
    end
  end

  bcd_counter2 u_left_score (
    .clk     (clk),
    .reset_i (reset),
    .clr_i   (clr_scores),
    .inc_i   (inc_left),
    .count_o (left_bcd)
  );

  bcd_counter2 u_right_score (
    .clk     (clk),
    .reset_i (reset),
    .clr_i   (clr_scores),
    .inc_i   (inc_right),
    .count_o (right_bcd)
  );

  assign graph_still = (state_q != ST_PLAY);
  assign ball_reset  = ball_reset_q;
  assign serve_dir   = serve_dir_q;
  assign left_score  = left_bcd;
  assign right_score = right_bcd;
  assign game_over   = (state_q == ST_OVER);
  assign winner      = winner_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Testbench for pong_game_ctrl. The driver issues directed game sequences and
// pushes the expected output snapshot for every state change it causes; the
// monitor pops one snapshot each time state_o changes and compares all
// outputs (plus cycles since the previous change where that is fixed).
module tb_pong_game_ctrl;

  localparam int WIN = 12;
  localparam int SF  = 60;
  localparam int OF  = 180;

  typedef struct packed {
    logic [2:0]  st;
    logic [7:0]  ls;
    logic [7:0]  rs;
    logic        sd;
    logic        gs;
    logic        go;
    logic        win;
    logic        br;
    logic        chk_dt;
    logic [15:0] dt;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic [1:0] btn1, btn2;
  logic       miss_left, miss_right;
  logic       graph_still, ball_reset, serve_dir, game_over, winner;
  logic [7:0] left_score, right_score;
  logic [2:0] state_o;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   done     = 0;

  // bench-side game model
  int   ls, rs;
  logic sd, win;

  pong_game_ctrl #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SF),
    .OVER_FRAMES  (OF),
    .TW           (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .btn1        (btn1),
    .btn2        (btn2),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .graph_still (graph_still),
    .ball_reset  (ball_reset),
    .serve_dir   (serve_dir),
    .left_score  (left_score),
    .right_score (right_score),
    .game_over   (game_over),
    .winner      (winner),
    .state_o     (state_o)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic void push_exp(input logic [2:0] st, input logic br,
                                   input logic chk, input int dt);
    exp_t e;
    e.st     = st;
    e.ls     = bcd(ls);
    e.rs     = bcd(rs);
    e.sd     = sd;
    e.gs     = (st != 3'd2);
    e.go     = (st == 3'd4);
    e.win    = win;
    e.br     = br;
    e.chk_dt = chk;
    e.dt     = 16'(dt);
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic report();
    if (!done) begin
      done = 1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
    end
  endtask

  // scoreboard monitor
  logic [2:0] prev_st;
  bit         seen = 0;
  int         dt_cnt = 0;
  always @(negedge clk) begin
    exp_t e;
    dt_cnt++;
    if (!seen || state_o != prev_st) begin
      seen    = 1;
      prev_st = state_o;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_state_change: got state %0d, required no change (t=%0t)",
                 state_o, $time);
      end else begin
        e = exp_q.pop_front();
        chk("state_o",     16'(state_o),     16'(e.st));
        chk("left_score",  16'(left_score),  16'(e.ls));
        chk("right_score", 16'(right_score), 16'(e.rs));
        chk("serve_dir",   16'(serve_dir),   16'(e.sd));
        chk("graph_still", 16'(graph_still), 16'(e.gs));
        chk("game_over",   16'(game_over),   16'(e.go));
        chk("winner",      16'(winner),      16'(e.win));
        chk("ball_reset",  16'(ball_reset),  16'(e.br));
        if (e.chk_dt) chk("cycles_in_prev_state", 16'(dt_cnt), e.dt);
      end
      dt_cnt = 0;
    end else begin
      // ball_reset is only ever high in the first cycle of a SERVE
      chk("ball_reset_pulse", 16'(ball_reset), 16'd0);
    end
  end

  // driver tasks
  task automatic tick_n(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
      if (noise && i < n - 1) begin
        miss_left = 1'b1; miss_right = 1'b1; btn1 = 2'b11; btn2 = 2'b11;
      end
      @(posedge clk); #1;
      miss_left = 1'b0; miss_right = 1'b0; btn1 = 2'b00; btn2 = 2'b00;
    end
  endtask

  task automatic start_game(input logic [1:0] b1, input logic [1:0] b2);
    ls = 0; rs = 0; sd = 1'b0; win = 1'b0;
    push_exp(3'd1, 1'b1, 1'b0, 0);
    push_exp(3'd2, 1'b0, 1'b1, 2 * SF - 1);
    // a tick together with the start press must not count toward SERVE
    btn1 = b1; btn2 = b2; frame_tick = 1'b1;
    @(posedge clk); #1;
    btn1 = 2'b00; btn2 = 2'b00; frame_tick = 1'b0;
    tick_n(SF, 1'b1);
  endtask

  task automatic point(input logic ml, input logic mr);
    bit over;
    if (ml && mr) sd = ~sd;
    else if (mr) begin ls++; sd = 1'b1; end
    else begin rs++; sd = 1'b0; end
    push_exp(3'd3, 1'b0, 1'b0, 0);
    over = (ls == WIN) || (rs == WIN);
    if (over) begin
      win = (rs == WIN);
      push_exp(3'd4, 1'b0, 1'b1, 1);
    end else begin
      push_exp(3'd1, 1'b1, 1'b1, 1);
    end
    miss_left = ml; miss_right = mr;
    @(posedge clk); #1;
    miss_left = 1'b0; miss_right = 1'b0;
    @(posedge clk); #1;
    if (over) begin
      push_exp(3'd0, 1'b0, 1'b1, 2 * OF - 1);
      tick_n(OF, 1'b1);
    end else begin
      push_exp(3'd2, 1'b0, 1'b1, 2 * SF - 1);
      tick_n(SF, 1'b1);
    end
  endtask

  task automatic chord_test();
`ifdef PONG_PAUSE_EN
    push_exp(3'd5, 1'b0, 1'b0, 0);
    btn1 = 2'b10; btn2 = 2'b10;
    @(posedge clk); #1;                 // now in PAUSE, chord still held
    @(posedge clk); #1;
    btn1 = 2'b00; btn2 = 2'b00; miss_left = 1'b1;
    @(posedge clk); #1;
    miss_left = 1'b0;
    @(posedge clk); #1;
    push_exp(3'd2, 1'b0, 1'b1, 4);
    btn1 = 2'b10; btn2 = 2'b10;
    @(posedge clk); #1;
    btn1 = 2'b00; btn2 = 2'b00;
    @(posedge clk); #1;
`else
    btn1 = 2'b10; btn2 = 2'b10;
    repeat (2) @(posedge clk);
    #1;
    btn1 = 2'b00; btn2 = 2'b00;
    @(posedge clk); #1;
`endif
  endtask

  initial begin : driver
    reset = 1'b1; frame_tick = 1'b0; btn1 = 2'b00; btn2 = 2'b00;
    miss_left = 1'b0; miss_right = 1'b0;
    ls = 0; rs = 0; sd = 1'b0; win = 1'b0;
    push_exp(3'd0, 1'b0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // game 1: left wins 12 - 1, passing 09 -> 10
    start_game(2'b01, 2'b00);
    point(1'b0, 1'b1);
    point(1'b1, 1'b0);
    point(1'b1, 1'b1);
    repeat (WIN - 1) point(1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // game 2: chord, reach 03/05, then reset with a miss pending
    start_game(2'b00, 2'b10);
    chord_test();
    repeat (5) point(1'b1, 1'b0);
    repeat (3) point(1'b0, 1'b1);
    ls = 0; rs = 0; sd = 1'b0; win = 1'b0;
    push_exp(3'd0, 1'b0, 1'b0, 0);
    reset = 1'b1; miss_right = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; miss_right = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pending_expectations", 16'(exp_q.size()), 16'd0);
    report();
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog: got timeout, required completion within 20000 cycles");
      report();
    end
  end

endmodule
